armleocpu_ptw: RTL
==================

// Module: armleocpu_ptw
// PURPOSE
//  Sv32 hardware page table walker for the ArmleoCPU cache/TLB subsystem.
//  - On a TLB miss, the cache issues one resolve request.
//  - The walker reads up to two PTEs over a single-beat memory read port.
//  - It returns the leaf PPN and the PTE access tag (PTE[7:0]) for the TLB write.
//  - It flags structural pagefaults and access faults.
//  - Privilege, SUM/MXR, A/D and R/W/X permission checks are not done here. The pagefault checker applies them downstream on the returned tag.
// PARAMETERS
//  TIMEOUT_CYCLES  0   memory wait limit per PTE read, in cycles; 0 disables the timeout
// PORTS
//  clk                       in   1   clock; all state changes on posedge
//  rst                       in   1   synchronous reset, active-high
//  resolve_request           in   1   walk request; sampled only in IDLE
//  resolve_virtual_address   in   20  VPN[19:0]; VPN1=[19:10], VPN0=[9:0]
//  satp_ppn                  in   22  root page table PPN; sampled with the request
//  resolve_ack               out  1   one-cycle pulse: request accepted
//  resolve_done              out  1   one-cycle pulse: result valid
//  resolve_pagefault         out  1   valid with done: invalid/structural PTE fault
//  resolve_accessfault       out  1   valid with done: memory error or timeout
//  resolve_physical_address  out  22  valid with done: leaf PPN
//  resolve_metadata          out  8   valid with done: PTE[7:0] {D,A,G,U,X,W,R,V}
//  mem_read                  out  1   PTE read request, held until mem_done
//  mem_address               out  34  physical byte address of the PTE; stable while mem_read is high
//  mem_done                  in   1   read completes this cycle
//  mem_error                 in   1   qualified by mem_done: bus error
//  mem_read_data             in   32  PTE; qualified by mem_done
// BEHAVIOUR
//  Reset values
//   - State IDLE. mem_read, resolve_ack, resolve_done, both fault flags = 0.
//   - resolve_physical_address, resolve_metadata, mem_address = 0. Timeout counter = 0.
//  IDLE
//   - resolve_request=1: latch VPN and satp_ppn, pulse resolve_ack.
//   - mem_address <= {satp_ppn,12'b0} + VPN1*4. level <= 1. Go to READ.
//   - mem_done while IDLE is ignored.
//  READ
//   - mem_read=1. The counter increments each cycle without mem_done.
//   - mem_done & mem_error: accessfault=1, go to RESPOND.
//   - TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without mem_done: accessfault=1, go to RESPOND.
//   - mem_done & !mem_error: decode PTE.
//     - V=0, or (R=0 & W=1): pagefault, go to RESPOND.
//     - Leaf (R|X) at level 1 with PTE[19:10]!=0 (misaligned superpage): pagefault.
//     - Leaf at level 1 otherwise: PPN = {PTE[31:20], VPN0}, go to RESPOND.
//     - Leaf at level 0: PPN = PTE[31:10], go to RESPOND.
//     - Pointer (R=X=0, V=1) at level 1: mem_address <= {PTE[31:10],12'b0} + VPN0*4, level <= 0, counter <= 0.
//       Stay in READ; mem_read stays high and the new address is presented the next cycle.
//     - Pointer at level 0: pagefault.
//   - resolve_metadata <= PTE[7:0] on every decoded PTE. It holds 0 on accessfault.
//  RESPOND
//   - resolve_done=1 for exactly one cycle, then IDLE.
//   - Result outputs hold until the next acceptance.
//   - mem_read=0 in RESPOND and IDLE.
//  Fault flags are mutually exclusive. On any fault, resolve_physical_address = 0.
//  Latency: request at cycle 0 -> mem_read from cycle 1 -> done one cycle after the final mem_done.
//   Minimum: superpage 2 cycles, 4K page 3 cycles.
//  Address arithmetic is 34-bit unsigned; there is no wrap check.
//  rst mid-walk: return to IDLE next edge and drop mem_read. A late mem_done is ignored.
//  A request arriving during READ/RESPOND is not acked; the requester holds it.
// TESTING
//  1. 4K walk: satp_ppn=22'h80, VPN=20'h00401.
//     - Expect mem_address=34'h80004; return 32'h00020401.
//     - Expect mem_address=34'h81004; return 32'h048D14CF.
//     - Expect done, PPN=22'h012345, metadata=8'hCF, no faults.
//  2. Superpage: VPN=20'h00401, L1 PTE=32'h300000CF -> one read only, PPN=22'h0C0001, metadata=8'hCF.
//  3. Structural faults, each -> pagefault=1, PPN=0:
//     - misaligned superpage 32'h300004CF
//     - W-only PTE 32'h00000005
//     - V=0 PTE 32'h0
//     - level-0 pointer 32'h00020401
//  4. Memory error: mem_done=1 & mem_error=1 on the L0 read -> accessfault=1, pagefault=0, metadata=0.
//  5. Timeout: TIMEOUT_CYCLES=8, mem_done never asserted -> done with accessfault exactly 8 cycles after mem_read rises.
//  6. rst asserted while in READ, then mem_done pulsed -> IDLE, mem_read=0, no resolve_done.
//     A new request afterwards is acked and completes normally.

Source files
------------

// File: rtl/armleocpu_ptw_if.sv
// Resolve handshake plus single-beat PTE read port of the Sv32 page table walker.
// The walker connects through the slave modport; the cache/memory side uses master.
interface armleocpu_ptw_if;
  logic        resolve_request;
  logic [19:0] resolve_virtual_address;
  logic [21:0] satp_ppn;
  logic        resolve_ack;
  logic        resolve_done;
  logic        resolve_pagefault;
  logic        resolve_accessfault;
  logic [21:0] resolve_physical_address;
  logic [7:0]  resolve_metadata;
  logic        mem_read;
  logic [33:0] mem_address;
  logic        mem_done;
  logic        mem_error;
  logic [31:0] mem_read_data;

  modport slave (
    input  resolve_request, resolve_virtual_address, satp_ppn,
    output resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault,
    output resolve_physical_address, resolve_metadata,
    output mem_read, mem_address,
    input  mem_done, mem_error, mem_read_data
  );

  modport master (
    output resolve_request, resolve_virtual_address, satp_ppn,
    input  resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault,
    input  resolve_physical_address, resolve_metadata,
    input  mem_read, mem_address,
    output mem_done, mem_error, mem_read_data
  );
endinterface

// File: rtl/armleocpu_ptw.sv
// Sv32 hardware page table walker: up to two PTE reads per request, returns leaf PPN
// and PTE[7:0]; reports structural pagefaults and memory access faults/timeouts.
module armleocpu_ptw #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  armleocpu_ptw_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, RESPOND} state_t;

  state_t      state_q, state_d;
  logic        level_q, level_d;
  logic [9:0]  vpn0_q, vpn0_d;
  logic [31:0] cnt_q, cnt_d;
  logic [33:0] mem_address_q, mem_address_d;
  logic        pagefault_q, pagefault_d;
  logic        accessfault_q, accessfault_d;
  logic [21:0] phys_q, phys_d;
  logic [7:0]  meta_q, meta_d;

  logic [31:0] pte;
  logic        pte_v, pte_r, pte_w, pte_x;

  assign pte   = bus.mem_read_data;
  assign pte_v = pte[0];
  assign pte_r = pte[1];
  assign pte_w = pte[2];
  assign pte_x = pte[3];

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    vpn0_d        = vpn0_q;
    cnt_d         = cnt_q;
    mem_address_d = mem_address_q;
    pagefault_d   = pagefault_q;
    accessfault_d = accessfault_q;
    phys_d        = phys_q;
    meta_d        = meta_q;
    unique case (state_q)
      IDLE: begin
        if (bus.resolve_request) begin
          vpn0_d        = bus.resolve_virtual_address[9:0];
          level_d       = 1'b1;
          cnt_d         = '0;
          mem_address_d = {bus.satp_ppn, 12'b0}
                        + {22'b0, bus.resolve_virtual_address[19:10], 2'b0};
          pagefault_d   = 1'b0;
          accessfault_d = 1'b0;
          phys_d        = '0;
          meta_d        = '0;
          state_d       = READ;
        end
      end
      READ: begin
        if (bus.mem_done) begin
          if (bus.mem_error) begin
            accessfault_d = 1'b1;
            phys_d        = '0;
            meta_d        = '0;
            state_d       = RESPOND;
          end else begin
            meta_d = pte[7:0];
            if (!pte_v || (!pte_r && pte_w)) begin
              pagefault_d = 1'b1;
              phys_d      = '0;
              state_d     = RESPOND;
            end else if (pte_r || pte_x) begin
              state_d = RESPOND;
              if (level_q && (pte[19:10] != 10'b0)) begin
                pagefault_d = 1'b1;
                phys_d      = '0;
              end else if (level_q) begin
                phys_d = {pte[31:20], vpn0_q};
              end else begin
                phys_d = pte[31:10];
              end
            end else if (level_q) begin
              // Pointer: keep mem_read high and present the L0 address next cycle
              mem_address_d = {pte[31:10], 12'b0} + {22'b0, vpn0_q, 2'b0};
              level_d       = 1'b0;
              cnt_d         = '0;
            end else begin
              pagefault_d = 1'b1;
              phys_d      = '0;
              state_d     = RESPOND;
            end
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
          accessfault_d = 1'b1;
          phys_d        = '0;
          meta_d        = '0;
          state_d       = RESPOND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      level_q       <= 1'b0;
      vpn0_q        <= '0;
      cnt_q         <= '0;
      mem_address_q <= '0;
      pagefault_q   <= 1'b0;
      accessfault_q <= 1'b0;
      phys_q        <= '0;
      meta_q        <= '0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      vpn0_q        <= vpn0_d;
      cnt_q         <= cnt_d;
      mem_address_q <= mem_address_d;
      pagefault_q   <= pagefault_d;
      accessfault_q <= accessfault_d;
      phys_q        <= phys_d;
      meta_q        <= meta_d;
    end
  end

  always_comb begin
    bus.resolve_ack              = (state_q == IDLE) && bus.resolve_request;
    bus.resolve_done             = (state_q == RESPOND);
    bus.resolve_pagefault        = pagefault_q;
    bus.resolve_accessfault      = accessfault_q;
    bus.resolve_physical_address = phys_q;
    bus.resolve_metadata         = meta_q;
    bus.mem_read                 = (state_q == READ);
    bus.mem_address              = mem_address_q;
  end

endmodule
